// File: rtl/if_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_queue
//  Description : Instruction-fetch front end. Owns the fetch PC, keeps at
//                most one word request in flight to instruction memory, and
//                buffers each returned instruction with its PC+4 in a small
//                FIFO. Decode drains the FIFO under a valid/ready handshake.
//                A redirect from branch resolution flushes the FIFO and
//                restarts fetch at the new PC. If a request is still in
//                flight when the redirect arrives, its late response is
//                dropped.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DEPTH      FIFO entries (power of two, >= 2)
//    RESET_PC   fetch PC loaded at reset
//  Optional build macro
//    FETCH_BYPASS_EN  When defined, a response that arrives while the FIFO
//                     is empty and decode is ready goes straight to the
//                     id_* outputs in the same cycle and is not pushed.
//  Ports
//    clk                 rising-edge clock
//    reset               synchronous active-low reset (0 = in reset)
//    imem_req_valid/addr/ready   fetch request channel (addr = PC)
//    imem_rsp_valid/data         fetch response, one pulse per request
//    redirect_valid/pc           one-cycle redirect to a new fetch PC
//    id_valid/pc4/instr/ready    FIFO head towards decode
//    pc_out              current fetch PC
//    queue_count         occupied FIFO entries
// ============================================================================
module if_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     imem_req_valid,
    output logic [31:0]              imem_req_addr,
    input  logic                     imem_req_ready,
    input  logic                     imem_rsp_valid,
    input  logic [31:0]              imem_rsp_data,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    output logic                     id_valid,
    output logic [31:0]              id_pc4,
    output logic [31:0]              id_instr,
    input  logic                     id_ready,
    output logic [31:0]              pc_out,
    output logic [$clog2(DEPTH):0]   queue_count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);

    localparam logic [0:0] c_ST_REQ  = 1'b0;
    localparam logic [0:0] c_ST_WAIT = 1'b1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]          r_state_q,  w_state_d;
    logic [31:0]         r_pc_q,     w_pc_d;
    logic [31:0]         r_req_pc_q, w_req_pc_d;
    logic                r_drop_q,   w_drop_d;
    logic [c_CNT_W-1:0]  r_count_q,  w_count_d;
    logic [c_PTR_W-1:0]  r_rd_ptr_q, w_rd_ptr_d;
    logic [c_PTR_W-1:0]  r_wr_ptr_q, w_wr_ptr_d;

    logic [31:0]         r_fifo_pc4_q   [DEPTH];
    logic [31:0]         r_fifo_instr_q [DEPTH];

    // ------------------------------------------------------------------
    // Event decode
    // ------------------------------------------------------------------
    logic w_not_empty;
    logic w_req_valid;
    logic w_req_fire;
    logic w_rsp_keep;
    logic w_bypass;
    logic w_push;
    logic w_pop;

    assign w_not_empty = (r_count_q != '0);

    // A request is only issued when a slot is free, so the matching
    // response always has room even though decode may be stalled.
    // The reset term keeps the request quiet while reset is held.
    assign w_req_valid = reset && (r_state_q == c_ST_REQ) &&
                         (r_count_q < c_DEPTH_CNT) && !redirect_valid;
    assign w_req_fire  = w_req_valid && imem_req_ready;

    // Response worth keeping: expected, not stale, not flushed this cycle.
    assign w_rsp_keep  = (r_state_q == c_ST_WAIT) && imem_rsp_valid &&
                         !r_drop_q && !redirect_valid;

`ifdef FETCH_BYPASS_EN
    assign w_bypass = !w_not_empty && w_rsp_keep && id_ready;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_push = w_rsp_keep && !w_bypass;
    assign w_pop  = w_not_empty && id_ready && !redirect_valid;

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_pc_q;
    assign pc_out         = r_pc_q;
    assign queue_count    = r_count_q;

    always_comb begin
        id_valid = w_not_empty;
        id_pc4   = 32'h0;
        id_instr = 32'h0;
        if (w_not_empty) begin
            id_pc4   = r_fifo_pc4_q[r_rd_ptr_q];
            id_instr = r_fifo_instr_q[r_rd_ptr_q];
        end
`ifdef FETCH_BYPASS_EN
        else if (w_bypass) begin
            id_valid = 1'b1;
            id_pc4   = r_req_pc_q + 32'd4;
            id_instr = imem_rsp_data;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Next-state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d  = r_state_q;
        w_pc_d     = r_pc_q;
        w_req_pc_d = r_req_pc_q;
        w_drop_d   = r_drop_q;
        w_count_d  = r_count_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_wr_ptr_d = r_wr_ptr_q;

        // FIFO bookkeeping; push and pop are already masked by redirect.
        case ({w_push, w_pop})
            2'b10:   w_count_d = r_count_q + c_CNT_W'(1);
            2'b01:   w_count_d = r_count_q - c_CNT_W'(1);
            default: w_count_d = r_count_q;
        endcase
        if (w_push) begin
            w_wr_ptr_d = r_wr_ptr_q + c_PTR_W'(1);
        end
        if (w_pop) begin
            w_rd_ptr_d = r_rd_ptr_q + c_PTR_W'(1);
        end

        if (redirect_valid) begin
            w_pc_d     = redirect_pc;
            w_count_d  = '0;
            w_rd_ptr_d = '0;
            w_wr_ptr_d = '0;
            if (r_state_q == c_ST_WAIT) begin
                if (imem_rsp_valid) begin
                    // The outstanding response is consumed and discarded now.
                    w_state_d = c_ST_REQ;
                    w_drop_d  = 1'b0;
                end else begin
                    // Response still to come; it belongs to the old path.
                    w_drop_d  = 1'b1;
                end
            end
        end else begin
            case (r_state_q)
                c_ST_REQ: begin
                    if (w_req_fire) begin
                        w_req_pc_d = r_pc_q;
                        w_pc_d     = r_pc_q + 32'd4;
                        w_state_d  = c_ST_WAIT;
                    end
                end
                default: begin
                    if (imem_rsp_valid) begin
                        w_drop_d  = 1'b0;
                        w_state_d = c_ST_REQ;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state_q  <= c_ST_REQ;
            r_pc_q     <= RESET_PC;
            r_req_pc_q <= RESET_PC;
            r_drop_q   <= 1'b0;
            r_count_q  <= '0;
            r_rd_ptr_q <= '0;
            r_wr_ptr_q <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_pc_q     <= w_pc_d;
            r_req_pc_q <= w_req_pc_d;
            r_drop_q   <= w_drop_d;
            r_count_q  <= w_count_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_wr_ptr_q <= w_wr_ptr_d;
        end
    end

    // Storage needs no reset: outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (reset && w_push) begin
            r_fifo_pc4_q[r_wr_ptr_q]   <= r_req_pc_q + 32'd4;
            r_fifo_instr_q[r_wr_ptr_q] <= imem_rsp_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_fetch_queue
//  Description : Self-checking bench for if_fetch_queue. A queue-level
//                reference model predicts every output each cycle, and a
//                set of directed scenarios pins literal values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        id_valid;
    logic [31:0] id_pc4;
    logic [31:0] id_instr;
    logic        id_ready = 1'b0;
    logic [31:0] pc_out;
    logic [$clog2(DEPTH):0] queue_count;

    always #5 clk = ~clk;

    if_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_pc4         (id_pc4),
        .id_instr       (id_instr),
        .id_ready       (id_ready),
        .pc_out         (pc_out),
        .queue_count    (queue_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tmo(input string nm);
        checks++;
        errors++;
        $display("FAIL %s got=no-event expected=event (t=%0t)", nm, $time);
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a == 32'h20) ? 32'h8C08_0000 : (32'h2010_0001 + a);
    endfunction

    // ------------------------------------------------------------------
    // Instruction memory: fixed latency, one response per accepted request
    // ------------------------------------------------------------------
    int          mem_lat = 1;
    logic        hs = 1'b0;
    logic [31:0] hs_addr = 32'h0;
    logic        rst_s = 1'b0;
    bit          pend = 0;
    int          rem = 0;
    logic [31:0] paddr = 32'h0;

    always @(negedge clk) begin
        hs      = reset && imem_req_valid && imem_req_ready;
        hs_addr = imem_req_addr;
        rst_s   = reset;
    end

    always @(posedge clk) begin
        #1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        if (!rst_s) begin
            pend = 0;
        end else begin
            if (hs) begin
                pend  = 1;
                rem   = mem_lat;
                paddr = hs_addr;
            end
            if (pend) begin
                if (rem <= 1) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_data(paddr);
                    pend = 0;
                end else begin
                    rem--;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Reference model: queue of {pc4, instr}, fetch PC, one outstanding
    // request with a "stale" flag. Checked every negedge, then advanced
    // to the state after the coming posedge.
    // ------------------------------------------------------------------
    logic [63:0] m_q[$];
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_req_pc = 32'h0;
    bit          m_busy = 0;
    bit          m_drop = 0;
    bit          m_init = 0;
    logic [31:0] log_pc4[$];
    logic [31:0] log_instr[$];

    always @(negedge clk) begin
        logic        e_rv;
        logic        e_iv;
        logic        byp;
        logic [31:0] e_pc4;
        logic [31:0] e_instr;
        int          n;
        n    = m_q.size();
        e_rv = reset && !m_busy && (n < DEPTH) && !redirect_valid;
        byp  = 1'b0;
`ifdef FETCH_BYPASS_EN
        byp  = m_busy && !m_drop && imem_rsp_valid && !redirect_valid &&
               (n == 0) && id_ready;
`endif
        e_iv    = (n != 0) || byp;
        e_pc4   = (n != 0) ? m_q[0][63:32] : (byp ? m_req_pc + 32'd4 : 32'h0);
        e_instr = (n != 0) ? m_q[0][31:0]  : (byp ? imem_rsp_data  : 32'h0);
        if (m_init) begin
            chk("m_req_valid", {31'h0, imem_req_valid}, {31'h0, e_rv});
            chk("m_req_addr",  imem_req_addr, m_pc);
            chk("m_pc_out",    pc_out, m_pc);
            chk("m_id_valid",  {31'h0, id_valid}, {31'h0, e_iv});
            chk("m_id_pc4",    id_pc4, e_pc4);
            chk("m_id_instr",  id_instr, e_instr);
            chk("m_count",     32'(queue_count), 32'(n));
        end
        if (reset && id_valid && id_ready && !redirect_valid) begin
            log_pc4.push_back(id_pc4);
            log_instr.push_back(id_instr);
        end
        if (!reset) begin
            m_init = 1;
            m_q.delete();
            m_pc   = RESET_PC;
            m_busy = 0;
            m_drop = 0;
        end else if (m_init) begin
            if (redirect_valid) begin
                m_q.delete();
                m_pc = redirect_pc;
                if (m_busy) begin
                    if (imem_rsp_valid) begin
                        m_busy = 0;
                        m_drop = 0;
                    end else begin
                        m_drop = 1;
                    end
                end
            end else begin
                if (n != 0 && id_ready) begin
                    void'(m_q.pop_front());
                end
                if (m_busy && imem_rsp_valid) begin
                    if (!m_drop && !byp) begin
                        m_q.push_back({m_req_pc + 32'd4, imem_rsp_data});
                    end
                    m_drop = 0;
                    m_busy = 0;
                end else if (e_rv && imem_req_ready) begin
                    m_req_pc = m_pc;
                    m_pc     = m_pc + 32'd4;
                    m_busy   = 1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic chk_log(input string nm, input int idx,
                           input logic [31:0] e_pc4, input logic [31:0] e_instr);
        if (log_pc4.size() > idx) begin
            chk({nm, "_pc4"},   log_pc4[idx],   e_pc4);
            chk({nm, "_instr"}, log_instr[idx], e_instr);
        end else begin
            tmo({nm, "_missing"});
        end
    endtask

    initial begin
        logic [31:0] exp_pc4 [4];
        bit          found;
        exp_pc4[0] = 32'h4;
        exp_pc4[1] = 32'h8;
        exp_pc4[2] = 32'hC;
        exp_pc4[3] = 32'h10;

        // Reset held for three cycles with memory ready
        reset = 1'b0;
        imem_req_ready = 1'b1;
        repeat (3) step();
        #1;
        chk("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
        chk("rst_id_valid",  {31'h0, id_valid}, 32'h0);
        chk("rst_count",     32'(queue_count), 32'h0);
        chk("rst_pc_out",    pc_out, 32'h0);
        chk("rst_id_pc4",    id_pc4, 32'h0);
        chk("rst_id_instr",  id_instr, 32'h0);

        // Streaming with 1-cycle memory
        reset = 1'b1;
        id_ready = 1'b1;
        mem_lat = 1;
        log_pc4.delete();
        log_instr.delete();
        #1;
        chk("first_req_valid", {31'h0, imem_req_valid}, 32'h1);
        chk("first_req_addr",  imem_req_addr, 32'h0);
        repeat (12) step();
        for (int i = 0; i < 3; i++) begin
            chk_log("stream", i, exp_pc4[i], 32'h2010_0001 + exp_pc4[i] - 32'd4);
        end

        // Decode stalled until the queue fills
        id_ready = 1'b0;
        do_reset();
        repeat (14) step();
        #1;
        chk("full_count",     32'(queue_count), 32'd4);
        chk("full_req_valid", {31'h0, imem_req_valid}, 32'h0);
        chk("full_req_addr",  imem_req_addr, 32'h10);
        log_pc4.delete();
        log_instr.delete();
        id_ready = 1'b1;
        repeat (8) step();
        for (int i = 0; i < 4; i++) begin
            chk_log("drain", i, exp_pc4[i], 32'h2010_0001 + exp_pc4[i] - 32'd4);
        end

        // Redirect while the request to 0x8 is outstanding
        mem_lat = 3;
        do_reset();
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            #1;
            if (imem_req_valid && imem_req_addr == 32'h8) found = 1;
        end
        if (!found) begin
            tmo("rdw_req8");
        end else begin
            step();
            log_pc4.delete();
            log_instr.delete();
            redirect_valid = 1'b1;
            redirect_pc    = 32'h100;
            step();
            redirect_valid = 1'b0;
            #1;
            chk("rdw_count", 32'(queue_count), 32'h0);
            repeat (20) step();
            chk_log("rdw_next", 0, 32'h104, 32'h2010_0101);
        end

        // Redirect colliding with a response and a pop, two entries queued
        mem_lat = 1;
        id_ready = 1'b0;
        do_reset();
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            #1;
            if (queue_count == 2 && imem_rsp_valid) found = 1;
        end
        if (!found) begin
            tmo("col_setup");
        end else begin
            redirect_valid = 1'b1;
            redirect_pc    = 32'h200;
            id_ready       = 1'b1;
            step();
            redirect_valid = 1'b0;
            id_ready       = 1'b0;
            #1;
            chk("col_count",     32'(queue_count), 32'h0);
            chk("col_id_valid",  {31'h0, id_valid}, 32'h0);
            chk("col_req_valid", {31'h0, imem_req_valid}, 32'h1);
            chk("col_req_addr",  imem_req_addr, 32'h200);
        end

        // PC wrap from the top of the address space
        id_ready = 1'b1;
        step();
        log_pc4.delete();
        log_instr.delete();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        repeat (12) step();
        chk_log("wrap0", 0, 32'h0, 32'h200F_FFFD);
        chk_log("wrap1", 1, 32'h4, 32'h2010_0001);

        // Response into an empty queue with decode ready
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h20;
        step();
        redirect_valid = 1'b0;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            #1;
            if (imem_rsp_valid) found = 1;
        end
        if (!found) begin
            tmo("byp_rsp");
        end else begin
            chk("byp_count", 32'(queue_count), 32'h0);
`ifdef FETCH_BYPASS_EN
            chk("byp_id_valid", {31'h0, id_valid}, 32'h1);
            chk("byp_id_pc4",   id_pc4, 32'h24);
            chk("byp_id_instr", id_instr, 32'h8C08_0000);
`else
            chk("byp_id_valid", {31'h0, id_valid}, 32'h0);
            chk("byp_id_pc4",   id_pc4, 32'h0);
`endif
            id_ready = 1'b0;
            step();
            #1;
`ifdef FETCH_BYPASS_EN
            chk("byp_count_after", 32'(queue_count), 32'h0);
`else
            chk("byp_count_after", 32'(queue_count), 32'h1);
            chk("byp_head_pc4",    id_pc4, 32'h24);
            chk("byp_head_instr",  id_instr, 32'h8C08_0000);
`endif
        end

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
